// File: rtl/operand_entry.sv
// operand_entry: key-event front end for the BCD calculator datapath.
// Turns single-cycle key strobes into operand A/B, an operator code, a
// display-select code and a one-cycle compute request.
// Optional feature macro: CALC_CHAIN_EN (operator after a result chains the
// result into operand A). Without it, RESULT is unused.
module operand_entry #(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  KEY_VALID,
    input  logic [3:0]            KEY_CODE,
    input  logic [31:0]           RESULT,
    output logic [4*DIGITS-1:0]   OPA,
    output logic [4*DIGITS-1:0]   OPB,
    output logic [1:0]            OP,
    output logic [1:0]            DISP_SEL,
    output logic                  CALC_GO
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    // State encoding doubles as the display-select code.
    localparam logic [1:0] S_A   = 2'b00;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_RES = 2'b10;

    logic [1:0]    state_reg, state_next;
    logic [W-1:0]  opa_reg, opa_next;
    logic [W-1:0]  opb_reg, opb_next;
    logic [1:0]    op_reg, op_next;
    logic [CW-1:0] cnt_a_reg, cnt_a_next;
    logic [CW-1:0] cnt_b_reg, cnt_b_next;
    logic          calc_go_reg, calc_go_next;

    logic          is_digit, is_oper, is_equals, is_clear;
    logic [1:0]    key_op;
    logic          lead_zero_a, lead_zero_b;

    // RESULT is only consumed by the chaining feature.
    logic          unused_result;
    assign unused_result = ^RESULT;

    // Key classification and operator code extraction.
    always_comb begin
        is_digit  = (KEY_CODE < 4'd10);
        is_oper   = (KEY_CODE >= 4'hA) && (KEY_CODE <= 4'hD);
        is_equals = (KEY_CODE == 4'hE);
        is_clear  = (KEY_CODE == 4'hF);
        case (KEY_CODE)
            4'hA:    key_op = 2'b00;
            4'hB:    key_op = 2'b01;
            4'hC:    key_op = 2'b10;
            4'hD:    key_op = 2'b11;
            default: key_op = 2'b00;
        endcase
        // A zero typed into an empty operand is not counted as a digit.
        lead_zero_a = (KEY_CODE == 4'd0) && (cnt_a_reg == '0);
        lead_zero_b = (KEY_CODE == 4'd0) && (cnt_b_reg == '0);
    end

    // Next-state logic for the entry state machine and operand registers.
    always_comb begin
        state_next   = state_reg;
        opa_next     = opa_reg;
        opb_next     = opb_reg;
        op_next      = op_reg;
        cnt_a_next   = cnt_a_reg;
        cnt_b_next   = cnt_b_reg;
        calc_go_next = 1'b0;

        if (KEY_VALID) begin
            if (is_clear) begin
                state_next = S_A;
                opa_next   = '0;
                opb_next   = '0;
                op_next    = 2'b00;
                cnt_a_next = '0;
                cnt_b_next = '0;
            end else begin
                case (state_reg)
                    S_A: begin
                        if (is_digit) begin
                            // Full operand drops further digits, no shift-out.
                            if (cnt_a_reg < CNT_FULL) begin
                                opa_next = W'({opa_reg, KEY_CODE});
                                if (!lead_zero_a)
                                    cnt_a_next = cnt_a_reg + 1'b1;
                            end
                        end else if (is_oper) begin
                            // Empty A is simply taken as zero.
                            op_next    = key_op;
                            opb_next   = '0;
                            cnt_b_next = '0;
                            state_next = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (cnt_b_reg < CNT_FULL) begin
                                opb_next = W'({opb_reg, KEY_CODE});
                                if (!lead_zero_b)
                                    cnt_b_next = cnt_b_reg + 1'b1;
                            end
                        end else if (is_oper) begin
                            // Operator may be corrected only before B digits.
                            if (cnt_b_reg == '0)
                                op_next = key_op;
                        end else if (is_equals) begin
                            if (cnt_b_reg != '0) begin
                                calc_go_next = 1'b1;
                                state_next   = S_RES;
                            end
                        end
                    end
                    S_RES: begin
                        if (is_digit) begin
                            // New digit starts a fresh calculation.
                            opa_next   = W'(KEY_CODE);
                            opb_next   = '0;
                            cnt_a_next = (KEY_CODE != 4'd0) ? CW'(1) : '0;
                            cnt_b_next = '0;
                            state_next = S_A;
                        end
`ifdef CALC_CHAIN_EN
                        else if (is_oper) begin
                            // Result becomes a full operand A.
                            opa_next   = RESULT[W-1:0];
                            cnt_a_next = CNT_FULL;
                            op_next    = key_op;
                            opb_next   = '0;
                            cnt_b_next = '0;
                            state_next = S_B;
                        end
`endif
                    end
                    default: begin
                        state_next = S_A;
                    end
                endcase
            end
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg   <= S_A;
            opa_reg     <= '0;
            opb_reg     <= '0;
            op_reg      <= 2'b00;
            cnt_a_reg   <= '0;
            cnt_b_reg   <= '0;
            calc_go_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            opa_reg     <= opa_next;
            opb_reg     <= opb_next;
            op_reg      <= op_next;
            cnt_a_reg   <= cnt_a_next;
            cnt_b_reg   <= cnt_b_next;
            calc_go_reg <= calc_go_next;
        end
    end

    assign OPA      = opa_reg;
    assign OPB      = opb_reg;
    assign OP       = op_reg;
    assign DISP_SEL = state_reg;
    assign CALC_GO  = calc_go_reg;

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry: directed key sequences, a digit-list model
// compared against the outputs every cycle, plus literal spot checks.
module tb_operand_entry;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         KEY_VALID = 1'b0;
    logic [3:0]   KEY_CODE = 4'd0;
    logic [31:0]  RESULT = 32'd0;
    logic [W-1:0] OPA, OPB;
    logic [1:0]   OP, DISP_SEL;
    logic         CALC_GO;

    operand_entry #(.DIGITS(DIGITS)) dut (
        .CLK(CLK), .RST_N(RST_N), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
        .RESULT(RESULT), .OPA(OPA), .OPB(OPB), .OP(OP), .DISP_SEL(DISP_SEL),
        .CALC_GO(CALC_GO)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int go_count = 0;
    bit cmp_en = 1'b0;

    // Model: operands as lists of significant digits, mode 0=A 1=B 2=result.
    int         a_q[$];
    int         b_q[$];
    int         mode = 0;
    logic [1:0] m_op = 2'b00;
    logic       m_go = 1'b0;

    function automatic logic [W-1:0] pack(input int q[$]);
        logic [W-1:0] v;
        logic [3:0]   d;
        v = '0;
        foreach (q[i]) begin
            d = 4'(q[i]);
            v = {v[W-5:0], d};
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the sampled inputs.
    always @(posedge CLK) begin
        int c;
        c = int'(KEY_CODE);
        m_go = 1'b0;
        if (!RST_N || (KEY_VALID && c == 15)) begin
            a_q.delete(); b_q.delete(); mode = 0; m_op = 2'b00;
        end else if (KEY_VALID) begin
            if (c < 10) begin
                if (mode == 0) begin
                    if (a_q.size() < DIGITS && !(a_q.size() == 0 && c == 0)) a_q.push_back(c);
                end else if (mode == 1) begin
                    if (b_q.size() < DIGITS && !(b_q.size() == 0 && c == 0)) b_q.push_back(c);
                end else begin
                    a_q.delete(); b_q.delete();
                    if (c != 0) a_q.push_back(c);
                    mode = 0;
                end
            end else if (c <= 13) begin
                if (mode == 0) begin
                    m_op = 2'(c - 10); b_q.delete(); mode = 1;
                end else if (mode == 1) begin
                    if (b_q.size() == 0) m_op = 2'(c - 10);
                end else begin
`ifdef CALC_CHAIN_EN
                    a_q.delete();
                    for (int i = DIGITS - 1; i >= 0; i--) a_q.push_back(int'((RESULT >> (4 * i)) & 32'hF));
                    m_op = 2'(c - 10); b_q.delete(); mode = 1;
`endif
                end
            end else if (c == 14) begin
                if (mode == 1 && b_q.size() > 0) begin
                    m_go = 1'b1; mode = 2;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_opa", 32'(OPA), 32'(pack(a_q)));
            chk("m_opb", 32'(OPB), 32'(pack(b_q)));
            chk("m_op", 32'(OP), 32'(m_op));
            chk("m_disp", 32'(DISP_SEL), 32'(mode));
            chk("m_go", 32'(CALC_GO), 32'(m_go));
            if (CALC_GO) go_count++;
        end
    end

    // One key strobe; called at a falling edge, returns at the next one.
    task automatic key(input logic [3:0] c);
        KEY_VALID = 1'b1;
        KEY_CODE  = c;
        @(negedge CLK);
        KEY_VALID = 1'b0;
        $display("key %h rst_n=%0b -> OPA=%h OPB=%h OP=%b DISP=%b GO=%b",
                 c, RST_N, OPA, OPB, OP, DISP_SEL, CALC_GO);
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) key(seq[i]);
    endtask

    initial begin
        int g0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        cmp_en = 1'b1;
        chk("rst_opa", 32'(OPA), 32'h0);
        chk("rst_opb", 32'(OPB), 32'h0);
        chk("rst_disp", 32'(DISP_SEL), 32'h0);
        chk("rst_go", 32'(CALC_GO), 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        keys('{4'd1, 4'd2, 4'd3});
        chk("t1_opa", 32'(OPA), 32'h0123);
        chk("t1_disp", 32'(DISP_SEL), 32'h0);
        chk("t1_nogo", 32'(go_count), 32'd0);

        key(4'hF);
        keys('{4'd0, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9});
        chk("t2_opa", 32'(OPA), 32'h5678);

        key(4'hF);
        keys('{4'd4, 4'd2, 4'hB, 4'd7});
        key(4'hE);
        chk("t3_go", 32'(CALC_GO), 32'h1);
        @(negedge CLK);
        chk("t3_go_off", 32'(CALC_GO), 32'h0);
        chk("t3_disp", 32'(DISP_SEL), 32'h2);
        chk("t3_opa", 32'(OPA), 32'h0042);
        chk("t3_opb", 32'(OPB), 32'h0007);
        chk("t3_op", 32'(OP), 32'h1);

        // New digit in result state starts over in A.
        key(4'd7);
        chk("t3b_opa", 32'(OPA), 32'h0007);
        chk("t3b_disp", 32'(DISP_SEL), 32'h0);

        key(4'hF);
        g0 = go_count;
        keys('{4'd9, 4'hA, 4'hC, 4'd3});
        key(4'hB);               // operator after a B digit is ignored
        chk("t4_op_hold", 32'(OP), 32'h2);
        key(4'hE);
        key(4'hE);
        chk("t4_op", 32'(OP), 32'h2);
        chk("t4_go2", 32'(CALC_GO), 32'h0);
        chk("t4_gocnt", 32'(go_count - g0), 32'd1);

        // Clear together with reset, then clear alone.
        key(4'hF);
        keys('{4'd1, 4'hB, 4'd1, 4'd2});
        chk("t5_opb", 32'(OPB), 32'h0012);
        RST_N = 1'b0;
        key(4'hF);
        RST_N = 1'b1;
        chk("t5_opa", 32'(OPA), 32'h0);
        chk("t5_opb0", 32'(OPB), 32'h0);
        chk("t5_disp", 32'(DISP_SEL), 32'h0);
        keys('{4'd1, 4'hB, 4'd1, 4'd2});
        key(4'hF);
        chk("t5f_opb", 32'(OPB), 32'h0);
        chk("t5f_op", 32'(OP), 32'h0);
        chk("t5f_disp", 32'(DISP_SEL), 32'h0);

        // Equals in A and in empty B are ignored.
        keys('{4'd8, 4'hE, 4'hD, 4'd0, 4'hE});
        chk("t6_disp", 32'(DISP_SEL), 32'h1);
        chk("t6_op", 32'(OP), 32'h3);

        // Operator in result state.
        key(4'hF);
        keys('{4'd4, 4'd2, 4'hB, 4'd7, 4'hE});
        RESULT = 32'h0000_1234;
        key(4'hA);
`ifdef CALC_CHAIN_EN
        chk("t7_opa", 32'(OPA), 32'h1234);
        chk("t7_op", 32'(OP), 32'h0);
        chk("t7_opb", 32'(OPB), 32'h0);
        chk("t7_disp", 32'(DISP_SEL), 32'h1);
        keys('{4'd5, 4'hE});
        chk("t7_go", 32'(CALC_GO), 32'h1);
`else
        chk("t7_opa", 32'(OPA), 32'h0042);
        chk("t7_op", 32'(OP), 32'h1);
        chk("t7_opb", 32'(OPB), 32'h0007);
        chk("t7_disp", 32'(DISP_SEL), 32'h2);
`endif
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Key-event front end for the calculator datapath. Converts single-cycle key strobes into two BCD operands, an operator code and a display-select code.
- Drives the operand inputs and the 2-bit display selector of the display-path multiplexer (00 = operand A, 01 = operand B, 10 = result).
- Issues a one-cycle compute request to the ALU.

Parameters:
- DIGITS, 4, BCD digits per operand; operand width W = 4*DIGITS.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- KEY_VALID  in  1  one-cycle strobe; each high cycle is one key event
- KEY_CODE  in  4  0-9 digit, A add, B sub, C mul, D div, E equals, F clear
- RESULT  in  32  ALU result; used only with CALC_CHAIN_EN
- OPA  out  W  operand A, BCD, most significant digit first
- OPB  out  W  operand B, BCD
- OP  out  2  00 add, 01 sub, 10 mul, 11 div
- DISP_SEL  out  2  00 show A, 01 show B, 10 show result; 11 never driven
- CALC_GO  out  1  one-cycle compute request

Behaviour:
- Reset is synchronous and active-low on RST_N, in the single clock domain CLK. RST_N low at a rising edge overrides any key.
- Reset values: OPA=0, OPB=0, OP=00, DISP_SEL=00, CALC_GO=0, state S_A, digit counters cntA=cntB=0.
- All outputs are registered. The effect of a key appears the cycle after its KEY_VALID edge. CALC_GO is high for exactly that one cycle.
- Keys are ignored when KEY_VALID=0. Upstream supplies debounced single-cycle strobes; no internal edge detection.
- States: S_A (entering A, DISP_SEL=00), S_B (entering B, DISP_SEL=01), S_RES (result shown, DISP_SEL=10).
- Digit d in S_A:
  - If cntA<DIGITS: OPA <= {OPA[W-5:0], d}.
  - Leading zero (d=0 with cntA=0) leaves cntA at 0. Any other accepted digit increments cntA.
  - If cntA==DIGITS: digit is dropped and OPA is unchanged (no wrap, no shift-out).
- Digit in S_B: same rules using OPB and cntB.
- Digit in S_RES: clear OPA, OPB and both counters, load d as the first A digit, go to S_A.
- Operator in S_A: latch OP, clear OPB and cntB, go to S_B. An empty A is valid and is taken as 0.
- Operator in S_B with cntB==0: replaces OP and stays in S_B.
- Operator in S_B with cntB>0: ignored.
- Operator in S_RES: see Optional Feature.
- Equals:
  - In S_B with cntB>0: CALC_GO pulses, go to S_RES. OPA, OPB and OP are held stable while in S_RES.
  - In S_A, in S_B with cntB==0, and in S_RES: ignored, no CALC_GO.
- Clear (F) in any state: same values as reset, applied next cycle.
- Non-digit codes never alter the digit registers except as stated above.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: operator key in S_RES does the following:
  - OPA <= RESULT[W-1:0].
  - cntA <= DIGITS, so A is treated as full.
  - Latch the new OP, clear OPB and cntB, go to S_B.
  - The value in RESULT at the key cycle is used.
- Undefined: operator key in S_RES is ignored and the RESULT port is unused.

Test Plan:
- Reset then keys 1,2,3 -> OPA=0x0123, DISP_SEL=00, CALC_GO never high.
- Keys 0,0,5,6,7,8,9 -> OPA=0x5678. Leading zeros are not counted and the fifth digit is dropped.
- Keys 4,2,B,7,E -> OPA=0x0042, OP=01, OPB=0x0007. CALC_GO is high one cycle after the E strobe, then DISP_SEL=10.
- Keys 9,A,C,3,E -> OP=10 (the C replaces the A before any B digit), one CALC_GO. A second E strobe gives no CALC_GO.
- In S_B with OPB=0x0012, assert F and RST_N=0 in the same cycle -> all outputs reach their reset values next cycle. Same result with F alone.
- With CALC_CHAIN_EN, in S_RES with RESULT=0x00001234, key A -> OPA=0x1234, OP=00, OPB=0, DISP_SEL=01. Without the macro the same key leaves all outputs unchanged.
